dmem_responder: RTL

- Handshaked data-memory responder: the target end of the load/store interface that the pipeline's memory stage initiates.
- Accepts one request at a time, carrying address, write enable, write data and RV32I funct3 size code.
- Performs byte/half/word stores and sign/zero-extended loads after a programmable latency.
- Returns a response that the initiator must acknowledge; lets the core be moved off the single-cycle combinational data memory.

---
 rtl/dmem_responder_pkg.sv | 31 +++
 rtl/dmem_lane_unit.sv | 53 +++++
 rtl/dmem_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - funct3 size codes, FSM states and helpers for the data-memory responder
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // Reserved funct3 codes fall through to a full-word access.
  function automatic size_e sizeOf(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: sizeOf = SZ_BYTE;
      F3_H, F3_HU: sizeOf = SZ_HALF;
      default:     sizeOf = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - byte-lane steering for stores and extraction/extension for loads
module dmem_lane_unit
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addrLo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdWord,
  output logic [3:0]  byteEn,
  output logic [31:0] wdataLane,
  output logic [31:0] rdataExt
);

  size_e       size;
  logic [1:0]  lane;
  logic [7:0]  rdByte;
  logic [15:0] rdHalf;
  logic        isUnsigned;

  // Half and word lanes are forced aligned here; misalignment is judged by the caller.
  always_comb begin
    size       = sizeOf(funct3);
    isUnsigned = funct3[2];
    lane       = 2'b00;
    byteEn     = 4'b0000;
    wdataLane  = 32'h0;
    rdataExt   = 32'h0;
    rdByte     = 8'h0;
    rdHalf     = 16'h0;
    case (size)
      SZ_BYTE: begin
        lane      = addrLo;
        byteEn    = 4'b0001 << lane;
        wdataLane = {24'h0, wdata[7:0]} << {lane, 3'b000};
        rdByte    = rdWord[{lane, 3'b000} +: 8];
        rdataExt  = isUnsigned ? {24'h0, rdByte} : {{24{rdByte[7]}}, rdByte};
      end
      SZ_HALF: begin
        lane      = {addrLo[1], 1'b0};
        byteEn    = 4'b0011 << lane;
        wdataLane = {16'h0, wdata[15:0]} << {lane, 3'b000};
        rdHalf    = rdWord[{lane[1], 4'b0000} +: 16];
        rdataExt  = isUnsigned ? {16'h0, rdHalf} : {{16{rdHalf[15]}}, rdHalf};
      end
      default: begin
        byteEn    = 4'b1111;
        wdataLane = wdata;
        rdataExt  = rdWord;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked load/store target with programmable latency
// Optional misaligned-access error reporting: define DMEM_MISALIGN_ERR_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       dm0
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

  logic [1:0]       state;
  logic [LAT_W-1:0] latCnt;
  logic             weReg;
  logic [IDX_W-1:0] idxReg;
  logic [1:0]       laneReg;
  logic [31:0]      wdataReg;
  logic [2:0]       f3Reg;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [3:0]  byteEn;
  logic [31:0] wdataLane;
  logic [31:0] rdataExt;
  logic [31:0] curWord;
  logic [31:0] mergedWord;
  logic        misaligned;
  logic        unusedAddrBits;

  // Upper address bits are deliberately dropped so accesses wrap around the array.
  assign unusedAddrBits = ^req_addr[ADDR_W-1:IDX_W+2];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign dm0       = mem[0];
  assign curWord   = mem[idxReg];

  dmem_lane_unit u_lane (
    .funct3    (f3Reg),
    .addrLo    (laneReg),
    .wdata     (wdataReg),
    .rdWord    (curWord),
    .byteEn    (byteEn),
    .wdataLane (wdataLane),
    .rdataExt  (rdataExt)
  );

  always_comb begin
    mergedWord = curWord;
    for (int b = 0; b < 4; b++) begin
      if (byteEn[b]) mergedWord[b*8 +: 8] = wdataLane[b*8 +: 8];
    end
  end

`ifdef DMEM_MISALIGN_ERR_EN
  always_comb begin
    case (sizeOf(f3Reg))
      SZ_HALF: misaligned = laneReg[0];
      SZ_WORD: misaligned = |laneReg;
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      latCnt    <= '0;
      weReg     <= 1'b0;
      idxReg    <= '0;
      laneReg   <= 2'b00;
      wdataReg  <= 32'h0;
      f3Reg     <= 3'b000;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            weReg    <= req_we;
            idxReg   <= req_addr[IDX_W+1:2];
            laneReg  <= req_addr[1:0];
            wdataReg <= req_wdata;
            f3Reg    <= req_funct3;
            latCnt   <= LAT_LOAD;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (latCnt == '0) begin
            if (weReg && !misaligned) mem[idxReg] <= mergedWord;
            rsp_rdata <= (weReg || misaligned) ? 32'h0 : rdataExt;
            rsp_err   <= misaligned;
            state     <= RESP;
          end else begin
            latCnt <= latCnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
